// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared constants and state encoding for the instruction
//               memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

    // Default instruction memory word-address width (1024 words)
    localparam int IM_ADDR_W = 10;

    // Instruction width and the number of host bytes that make one word
    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = INSTR_W / 8;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/im_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_byte_packer
// Description : Packs accepted host bytes big-endian into a 32-bit word.
//               Flags the handshake that completes a word and exposes the
//               completed word combinationally on that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader_byte_packer
    import im_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_accept,
    input  logic [7:0]         i_byte_data,
    output logic [INSTR_W-1:0] o_next_word,
    output logic               o_word_full
);

    logic [INSTR_W-1:0] r_shift;
    logic [1:0]         r_byte_idx;

    // Shift in each accepted byte at the low end so the first byte ends up
    // as the most-significant byte; clear discards any partial word.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shift    <= '0;
            r_byte_idx <= 2'd0;
        end else if (i_accept) begin
            r_shift    <= o_next_word;
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    // The word including the byte being accepted right now
    assign o_next_word = {r_shift[INSTR_W-9:0], i_byte_data};

    // The fourth byte of a word is on the bus and being taken this cycle
    assign o_word_full = i_accept && (r_byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Writer side of the instruction memory. Receives a host byte
//               stream, packs it big-endian into instructions and writes
//               them to consecutive word addresses while holding the CPU in
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               im_we,
    output logic [ADDR_W+1:0]  im_addr,
    output logic [INSTR_W-1:0] im_din,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    // Memory depth, one bit wider than word_count so the compare is exact
    localparam logic [CNT_W:0] c_depth = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_word_ptr;
    logic [ADDR_W+1:0]   r_im_addr;
    logic [INSTR_W-1:0]  r_im_din;
    logic                r_err;

    logic                w_accept;
    logic                w_clear;
    logic                w_word_full;
    logic [INSTR_W-1:0]  w_next_word;
    logic                w_over;
    logic [CNT_W-1:0]    w_ptr_next;
    logic                w_start_ok;
    logic                w_start_err;

    assign w_accept   = byte_valid && byte_ready;
    // Packer only holds a partial word while receiving
    assign w_clear    = (r_state != ST_RECV);
    assign w_over     = ({1'b0, word_count} > c_depth);
    // Compared at count width so a full-depth load terminates before wrap
    assign w_ptr_next = CNT_W'(r_word_ptr) + CNT_W'(1);

    im_loader_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_accept    (w_accept),
        .i_byte_data (byte_data),
        .o_next_word (w_next_word),
        .o_word_full (w_word_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and control outputs
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        im_we        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_start_ok   = 1'b0;
        w_start_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        w_state_next = ST_DONE;
                    end else if (w_over) begin
                        w_start_err = 1'b1;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_state_next = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_word_full) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                im_we = 1'b1;
                busy  = 1'b1;
                if (w_ptr_next == r_count) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RECV;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                busy         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Load bookkeeping and the write-port data/address registers. The
    // address and data are captured on the completing byte so they are
    // valid during the write cycle and then simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_word_ptr <= '0;
            r_im_addr  <= '0;
            r_im_din   <= '0;
        end else begin
            if (w_start_ok) begin
                r_count    <= word_count;
                r_word_ptr <= '0;
            end
            if (w_word_full) begin
                r_im_din  <= w_next_word;
                r_im_addr <= {r_word_ptr, 2'b00};
            end
            if (r_state == ST_WRITE) begin
                r_word_ptr <= r_word_ptr + ADDR_W'(1);
            end
        end
    end

    // Sticky oversize-request flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_err) begin
            r_err <= 1'b1;
        end
    end

    assign im_addr  = r_im_addr;
    assign im_din   = r_im_din;
    assign err      = r_err;
    assign cpu_hold = busy;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Scoreboard bench for im_loader. Stimulus pushes expected
//               writes; a negedge monitor pops and compares on every im_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  word_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W+1:0] im_addr;
    logic [31:0]       im_din;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              err;

    im_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_din     (im_din),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_din_q[$];
    int          exp_we       = 0;
    int          exp_done     = 0;
    int          we_count     = 0;
    int          done_seen    = 0;
    int          first_we_cyc = -1;
    int          last_done_cyc = -1;
    int          start_cyc    = 0;
    logic [31:0] last_we_addr = '0;
    logic        mon_en       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] addr, input logic [31:0] din);
        exp_addr_q.push_back(addr);
        exp_din_q.push_back(din);
        exp_we++;
    endtask

    // Present a start request; it is sampled at the next edge
    task automatic begin_load(input int cnt);
        start      = 1'b1;
        word_count = CNT_W'(cnt);
        start_cyc  = cyc;
    endtask

    // Hold a byte until the loader takes it, then idle for gap cycles
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc = 1'b0;
        int k   = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!acc && k < 20) begin
            acc = byte_ready;
            step();
            start = 1'b0;
            k++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) begin
            send_byte(w[31-8*b -: 8], gap);
        end
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_seen < target && k < 200) begin
            step();
            k++;
        end
        chk("done_pulse_count", 32'(done_seen), 32'(target));
    endtask

    // Monitor: interface invariants every cycle, scoreboard pop on each write
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cpu_hold_eq_busy", {31'd0, cpu_hold}, {31'd0, busy});
            chk("byte_ready_in_recv", {31'd0, byte_ready}, {31'd0, busy & ~im_we & ~done});
            if (im_we === 1'b1) begin
                we_count++;
                last_we_addr = 32'(im_addr);
                if (first_we_cyc < 0) first_we_cyc = cyc;
                chk("write_while_busy", {31'd0, busy}, 32'd1);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%03h din 0x%08h expected no write", im_addr, im_din);
                end else begin
                    chk("write_addr", 32'(im_addr), exp_addr_q.pop_front());
                    chk("write_din", im_din, exp_din_q.pop_front());
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                last_done_cyc = cyc;
            end
        end
    end

    logic [31:0] prog3 [3] = '{32'h3C011001, 32'h34240000, 32'h8C850000};
    logic [31:0] w;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) step();
        chk("rst_im_we",      {31'd0, im_we},      32'd0);
        chk("rst_im_addr",    32'(im_addr),        32'd0);
        chk("rst_im_din",     im_din,              32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step();

        // Single word, valid held high
        expect_word(32'h000, 32'h20080005);
        exp_done++;
        begin_load(1);
        send_word(32'h20080005, 0);
        wait_done(exp_done);
        chk("t1_we_latency",   32'(first_we_cyc - start_cyc),  32'd5);
        chk("t1_done_latency", 32'(last_done_cyc - start_cyc), 32'd6);
        chk("t1_busy_after",   {31'd0, busy}, 32'd0);
        chk("t1_din_hold",     im_din, 32'h20080005);

        // Three words back to back
        for (int i = 0; i < 3; i++) expect_word(32'(i * 4), prog3[i]);
        exp_done++;
        begin_load(3);
        for (int i = 0; i < 3; i++) send_word(prog3[i], 0);
        wait_done(exp_done);
        chk("t2_write_total", 32'(we_count), 32'(exp_we));

        // Throttled host: gap of 0..3 cycles after each byte
        expect_word(32'h000, 32'hDEADBEEF);
        expect_word(32'h004, 32'h01234567);
        exp_done++;
        begin_load(2);
        w = 32'hDEADBEEF;
        for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], b);
        w = 32'h01234567;
        for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8], 3 - b);
        wait_done(exp_done);
        chk("t3_write_total", 32'(we_count), 32'(exp_we));

        // Oversize request sets err and does nothing else
        begin_load(1025);
        step();
        start = 1'b0;
        step();
        chk("t4_err_set",    {31'd0, err},  32'd1);
        chk("t4_busy_low",   {31'd0, busy}, 32'd0);
        repeat (3) step();
        chk("t4_no_write",   32'(we_count), 32'(exp_we));

        // Zero-length request: immediate done, err stays set
        exp_done++;
        begin_load(0);
        step();
        start = 1'b0;
        wait_done(exp_done);
        chk("t4_zero_done_latency", 32'(last_done_cyc - start_cyc), 32'd1);
        chk("t4_zero_no_write", 32'(we_count), 32'(exp_we));
        chk("t4_err_sticky", {31'd0, err}, 32'd1);

        // Reset after two bytes of the second word aborts the load
        expect_word(32'h000, 32'hCAFEF00D);
        begin_load(2);
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        step();
        chk("t5_im_we",      {31'd0, im_we},      32'd0);
        chk("t5_im_addr",    32'(im_addr),        32'd0);
        chk("t5_im_din",     im_din,              32'd0);
        chk("t5_busy",       {31'd0, busy},       32'd0);
        chk("t5_cpu_hold",   {31'd0, cpu_hold},   32'd0);
        chk("t5_err",        {31'd0, err},        32'd0);
        chk("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
        rst = 1'b0;
        repeat (4) step();
        chk("t5_no_extra_write", 32'(we_count), 32'(exp_we));
        chk("t5_no_done",        32'(done_seen), 32'(exp_done));
        expect_word(32'h000, 32'h00000013);
        exp_done++;
        begin_load(1);
        send_word(32'h00000013, 0);
        wait_done(exp_done);

        // Full-depth load with a stray start in the middle
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i) ^ 16'hA5A5, 16'(i * 3)};
            expect_word(32'(i * 4), w);
        end
        exp_done++;
        begin_load(1024);
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i) ^ 16'hA5A5, 16'(i * 3)};
            if (i == 500) begin
                start      = 1'b1;
                word_count = CNT_W'(5);
            end
            send_word(w, 0);
        end
        wait_done(exp_done);
        chk("t6_last_addr",   last_we_addr, 32'hFFC);
        chk("t6_write_total", 32'(we_count), 32'(exp_we));
        repeat (3) step();

        chk("final_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("final_done_total",  32'(done_seen), 32'(exp_done));
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
